// File: rtl/match_controller.sv
// Purpose : round/match sequencer; clocks the round timer from vsync, tallies wins, gates player control.
// Latency : every output is registered; a cause on cycle N is visible on cycle N+1 (frame tick adds one cycle after the vsync fall).
// Backpr. : none; inputs are levels/pulses sampled every clk, outputs are free-running status.
//
// Ports:
//   clk, reset        system clock, synchronous active-low reset
//   vsync             VGA vsync (active-low); its falling edge is the frame tick
//   start             start button level; only its rising edge in IDLE/MATCH_OVER is used
//   p1_ko, p2_ko      player health depleted levels from game_logic
//   state             0 IDLE, 1 INTRO, 2 FIGHT, 3 KO, 4 MATCH_OVER
//   game_enable       high only while in FIGHT
//   round_reset_n     active-low pulse on the first cycle of every INTRO
//   round_time        round clock in seconds
//   round_num         current round, 1-based (0 before the first match)
//   p1_wins, p2_wins  round wins, saturating at 3
//   winner            0 none, 1 P1, 2 P2, 3 draw; meaningful in MATCH_OVER
module match_controller #(
    parameter int FPS           = 60,
    parameter int INTRO_FRAMES  = 120,
    parameter int KO_FRAMES     = 90,
    parameter int ROUND_SECONDS = 99,
    parameter int ROUNDS_TO_WIN = 2,
    parameter int MAX_ROUNDS    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vsync,
    input  logic       start,
    input  logic       p1_ko,
    input  logic       p2_ko,
    output logic [2:0] state,
    output logic       game_enable,
    output logic       round_reset_n,
    output logic [6:0] round_time,
    output logic [2:0] round_num,
    output logic [1:0] p1_wins,
    output logic [1:0] p2_wins,
    output logic [1:0] winner
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_INTRO      = 3'd1,
        S_FIGHT      = 3'd2,
        S_KO         = 3'd3,
        S_MATCH_OVER = 3'd4
    } state_t;

    localparam logic [15:0] INTRO_LAST = 16'(INTRO_FRAMES - 1);
    localparam logic [15:0] KO_LAST    = 16'(KO_FRAMES - 1);
    localparam logic [7:0]  FPS_LAST   = 8'(FPS - 1);
    localparam logic [6:0]  RT_LOAD    = 7'(ROUND_SECONDS);
    localparam logic [1:0]  WIN_TARGET = 2'(ROUNDS_TO_WIN);
    localparam logic [2:0]  RN_MAX     = 3'(MAX_ROUNDS);

    state_t      state_q, state_d;
    logic        vsync_q, start_q, frame_tick;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]  sec_div_q, sec_div_d;
    logic [6:0]  round_time_d;
    logic [2:0]  round_num_d;
    logic [1:0]  p1_wins_d, p2_wins_d, winner_d;
    logic        game_enable_d, round_reset_n_d;
    logic        start_rise, sec_wrap, time_up, enter_intro;

    function automatic logic [1:0] sat_inc(input logic [1:0] v);
        return (v == 2'd3) ? v : v + 2'd1;
    endfunction

    assign start_rise = start & ~start_q;
    assign sec_wrap   = frame_tick && (sec_div_q == FPS_LAST);
    // Time is up either because the clock already reads 0 or because this
    // tick's wrap takes it from 1 to 0; the round ends on that same edge.
    assign time_up    = (round_time == 7'd0) || (sec_wrap && (round_time == 7'd1));

    always_comb begin
        state_d      = state_q;
        frame_cnt_d  = frame_cnt_q;
        sec_div_d    = sec_div_q;
        round_time_d = round_time;
        round_num_d  = round_num;
        p1_wins_d    = p1_wins;
        p2_wins_d    = p2_wins;
        winner_d     = winner;

        unique case (state_q)
            S_IDLE: begin
                if (start_rise) begin
                    state_d     = S_INTRO;
                    p1_wins_d   = 2'd0;
                    p2_wins_d   = 2'd0;
                    round_num_d = 3'd1;
                    winner_d    = 2'd0;
                end
            end
            S_INTRO: begin
                if (frame_tick) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    if (frame_cnt_q == INTRO_LAST) state_d = S_FIGHT;
                end
            end
            S_FIGHT: begin
                if (frame_tick) begin
                    sec_div_d = sec_wrap ? 8'd0 : sec_div_q + 8'd1;
                    if (sec_wrap && (round_time != 7'd0)) round_time_d = round_time - 7'd1;
                end
                // A KO takes precedence over the clock running out.
                if (p1_ko || p2_ko) begin
                    state_d = S_KO;
                    if (p1_ko && !p2_ko) p2_wins_d = sat_inc(p2_wins);
                    if (p2_ko && !p1_ko) p1_wins_d = sat_inc(p1_wins);
                end else if (time_up) begin
                    state_d = S_KO;
                end
            end
            S_KO: begin
                if (frame_tick) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    if (frame_cnt_q == KO_LAST) begin
                        if ((p1_wins == WIN_TARGET) || (p2_wins == WIN_TARGET) ||
                            (round_num == RN_MAX)) begin
                            state_d = S_MATCH_OVER;
                            if (p1_wins > p2_wins)      winner_d = 2'd1;
                            else if (p2_wins > p1_wins) winner_d = 2'd2;
                            else                        winner_d = 2'd3;
                        end else begin
                            state_d     = S_INTRO;
                            round_num_d = (round_num < RN_MAX) ? round_num + 3'd1 : round_num;
                        end
                    end
                end
            end
            S_MATCH_OVER: begin
                if (start_rise) begin
                    state_d     = S_INTRO;
                    p1_wins_d   = 2'd0;
                    p2_wins_d   = 2'd0;
                    round_num_d = 3'd1;
                    winner_d    = 2'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Per-state counters always start from zero in the new state.
        if (state_d != state_q) begin
            frame_cnt_d = 16'd0;
            sec_div_d   = 8'd0;
        end

        enter_intro = (state_d == S_INTRO) && (state_q != S_INTRO);
        if (enter_intro) round_time_d = RT_LOAD;

        game_enable_d   = (state_d == S_FIGHT);
        round_reset_n_d = ~enter_intro;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            vsync_q       <= 1'b1;
            start_q       <= 1'b1;
            frame_tick    <= 1'b0;
            frame_cnt_q   <= 16'd0;
            sec_div_q     <= 8'd0;
            round_time    <= RT_LOAD;
            round_num     <= 3'd0;
            p1_wins       <= 2'd0;
            p2_wins       <= 2'd0;
            winner        <= 2'd0;
            game_enable   <= 1'b0;
            round_reset_n <= 1'b1;
        end else begin
            state_q       <= state_d;
            vsync_q       <= vsync;
            start_q       <= start;
            frame_tick    <= vsync_q & ~vsync;
            frame_cnt_q   <= frame_cnt_d;
            sec_div_q     <= sec_div_d;
            round_time    <= round_time_d;
            round_num     <= round_num_d;
            p1_wins       <= p1_wins_d;
            p2_wins       <= p2_wins_d;
            winner        <= winner_d;
            game_enable   <= game_enable_d;
            round_reset_n <= round_reset_n_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_match_controller.sv
// Purpose : scoreboard bench for match_controller with small frame/round parameters.
// Latency : expected snapshots are queued ahead; the monitor pops one per observed output change.
// Backpr. : none; stimulus runs on fixed cycle counts.
module tb_match_controller;

    logic       clk;
    logic       reset, vsync, start, p1_ko, p2_ko;
    logic [2:0] state;
    logic       game_enable, round_reset_n;
    logic [6:0] round_time;
    logic [2:0] round_num;
    logic [1:0] p1_wins, p2_wins, winner;

    match_controller #(
        .FPS(3), .INTRO_FRAMES(2), .KO_FRAMES(2),
        .ROUND_SECONDS(2), .ROUNDS_TO_WIN(2), .MAX_ROUNDS(3)
    ) dut (
        .clk(clk), .reset(reset), .vsync(vsync), .start(start),
        .p1_ko(p1_ko), .p2_ko(p2_ko), .state(state),
        .game_enable(game_enable), .round_reset_n(round_reset_n),
        .round_time(round_time), .round_num(round_num),
        .p1_wins(p1_wins), .p2_wins(p2_wins), .winner(winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       ge;
        logic [6:0] rt;
        logic [2:0] rn;
        logic [1:0] w1;
        logic [1:0] w2;
        logic [1:0] win;
    } snap_t;

    localparam snap_t RST_SNAP = '{st: 3'd0, ge: 1'b0, rt: 7'd2, rn: 3'd0, w1: 2'd0, w2: 2'd0, win: 2'd0};

    snap_t exp_q[$];
    snap_t cur, prev, e;
    logic  prev_rrn;
    logic  mon_en;
    int    tests = 0;
    int    failed = 0;
    int    pulses = 0;

    task automatic push(input logic [2:0] st, input logic ge, input logic [6:0] rt,
                        input logic [2:0] rn, input logic [1:0] w1, input logic [1:0] w2,
                        input logic [1:0] win);
        snap_t s;
        s = '{st: st, ge: ge, rt: rt, rn: rn, w1: w1, w2: w2, win: win};
        exp_q.push_back(s);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One vsync falling edge; ko = {p1_ko, p2_ko} is presented on the cycle
    // in which the resulting frame tick is consumed by the DUT.
    task automatic tick(input logic [1:0] ko);
        @(negedge clk) vsync = 1'b0;
        @(negedge clk) begin vsync = 1'b1; p1_ko = ko[1]; p2_ko = ko[0]; end
        @(negedge clk) begin p1_ko = 1'b0; p2_ko = 1'b0; end
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick(2'b00);
    endtask

    task automatic press_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Monitor: every change of the observable status is matched against the
    // next queued expectation; round_reset_n lows must be single-cycle and
    // coincide with the first INTRO cycle.
    initial begin
        prev     = RST_SNAP;
        prev_rrn = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                cur = '{st: state, ge: game_enable, rt: round_time, rn: round_num,
                        w1: p1_wins, w2: p2_wins, win: winner};
                if (cur !== prev) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        failed++;
                        $display("FAIL unexpected_change: got %p with nothing expected", cur);
                    end else begin
                        e = exp_q.pop_front();
                        if (cur !== e) begin
                            failed++;
                            $display("FAIL snapshot: got %p expected %p", cur, e);
                        end
                    end
                    if (cur.st == 3'd1 && prev.st != 3'd1) begin
                        tests++;
                        if (round_reset_n !== 1'b0) begin
                            failed++;
                            $display("FAIL intro_pulse: round_reset_n got %b expected 0", round_reset_n);
                        end
                    end
                end
                if (round_reset_n === 1'b0) begin
                    pulses++;
                    tests++;
                    if (!(cur.st == 3'd1 && prev.st != 3'd1) || prev_rrn !== 1'b1) begin
                        failed++;
                        $display("FAIL pulse_shape: low with state %0d prev_state %0d prev_rrn %b, expected first INTRO cycle only",
                                 cur.st, prev.st, prev_rrn);
                    end
                end
                prev     = cur;
                prev_rrn = round_reset_n;
            end
        end
    end

    initial begin
        reset = 1'b0; vsync = 1'b1; start = 1'b1; p1_ko = 1'b0; p2_ko = 1'b0; mon_en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", state, 0);
        check("rst_game_enable", game_enable, 0);
        check("rst_round_reset_n", round_reset_n, 1);
        check("rst_round_time", round_time, 2);
        check("rst_round_num", round_num, 0);
        check("rst_wins", {p1_wins, p2_wins, winner}, 0);
        mon_en = 1'b1;

        // Button held through reset release must not start a match.
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("held_start_idle", state, 0);
        start = 1'b0;
        repeat (2) @(negedge clk);

        // Match 1: three drawn rounds.
        push(1, 0, 2, 1, 0, 0, 0); press_start();
        push(2, 1, 2, 1, 0, 0, 0); ticks(2);
        push(2, 1, 1, 1, 0, 0, 0); ticks(3);
        push(3, 0, 0, 1, 0, 0, 0); ticks(3);
        push(1, 0, 2, 2, 0, 0, 0); ticks(2);
        push(2, 1, 2, 2, 0, 0, 0); ticks(2);
        push(2, 1, 1, 2, 0, 0, 0); ticks(3);
        push(3, 0, 0, 2, 0, 0, 0); ticks(2); tick(2'b11);   // double KO on the time-up tick
        push(1, 0, 2, 3, 0, 0, 0); ticks(2);
        push(2, 1, 2, 3, 0, 0, 0); ticks(2);
        push(2, 1, 1, 3, 0, 0, 0); ticks(3);
        push(3, 0, 0, 3, 0, 0, 0); ticks(3);
        push(4, 0, 0, 3, 0, 0, 3); ticks(2);
        check("draw_match_winner", winner, 3);
        check("draw_match_round", round_num, 3);

        // Match 2: P1 wins two rounds.
        push(1, 0, 2, 1, 0, 0, 0); press_start();
        check("restart_wins", {p1_wins, p2_wins}, 0);
        push(2, 1, 2, 1, 0, 0, 0); ticks(2);
        press_start();                                      // ignored in FIGHT
        repeat (2) @(negedge clk);
        check("start_ignored_fight", state, 2);
        push(3, 0, 2, 1, 1, 0, 0);
        @(negedge clk) p2_ko = 1'b1;
        @(posedge clk) #1;
        check("ko_next_cycle", state, 3);
        check("ko_p1_wins", p1_wins, 1);
        @(negedge clk) p2_ko = 1'b0;
        push(1, 0, 2, 2, 1, 0, 0); ticks(2);
        push(2, 1, 2, 2, 1, 0, 0); ticks(2);
        push(2, 1, 1, 2, 1, 0, 0); ticks(3);
        push(3, 0, 0, 2, 2, 0, 0); ticks(2); tick(2'b01);   // KO beats time-up
        push(4, 0, 0, 2, 2, 0, 1); ticks(2);
        check("p1_match_winner", winner, 1);

        // Match 3: reset in the middle of FIGHT.
        push(1, 0, 2, 1, 0, 0, 0); press_start();
        push(2, 1, 2, 1, 0, 0, 0); ticks(2);
        repeat (1) @(negedge clk);
        push(0, 0, 2, 0, 0, 0, 0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk) #1;
        check("midreset_state", state, 0);
        check("midreset_game_enable", game_enable, 0);
        check("midreset_rrn", round_reset_n, 1);
        @(negedge clk) reset = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_rrn", round_reset_n, 1);
        check("post_reset_state", state, 0);

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("rrn_pulse_count", pulses, 6);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
